// File: rtl/bus_target_pkg.sv
// Shared definitions for the bus_target memory responder: FSM encoding,
// default bus widths and the memory-mapped I/O port address.
package bus_target_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam logic [4:0] IO_ADDR = 5'h1F;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT     = 2'b01,
    S_RESP     = 2'b10,
    S_ERR_HOLD = 2'b11
  } state_t;

endpackage

// File: rtl/bus_target_mem.sv
// Resettable register array for bus_target: one synchronous write port and
// one combinational read port. Every word clears on reset.
module bus_target_mem
  import bus_target_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage: clear all words on reset, otherwise write on the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_target.sv
// Memory-side responder for the accumulator CPU bus. Reads complete after
// RD_LAT wait cycles, writes complete in one cycle, and protocol violations
// raise a one-cycle err pulse.
// Optional feature: define BUS_TARGET_IO_EN to map an output port register
// (io_out) at IO_ADDR; writes there update both io_out and the memory word.
module bus_target
  import bus_target_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
  output logic              busy,
  output logic              err
`ifdef BUS_TARGET_IO_EN
  ,
  output logic [DATA_W-1:0] io_out
`endif
);

  localparam logic [1:0] LAT_CNT = 2'(RD_LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_oe;
  logic              w_oe_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_latch;
  logic              w_cap;
  logic              w_we;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_rd_val;

  // A zero-latency read captures in IDLE from the live address; otherwise
  // the address latched at the start of the read is used.
  assign w_rd_addr = (r_state == S_IDLE) ? addr : r_addr;

  bus_target_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (addr),
    .i_wdata (wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_mem_rdata)
  );

`ifdef BUS_TARGET_IO_EN
  localparam logic [ADDR_W-1:0] IO_A = ADDR_W'(IO_ADDR);

  logic [DATA_W-1:0] r_io;

  // Output port register, written alongside the memory word at IO_A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_io <= '0;
    else if (w_we && (addr == IO_A)) r_io <= wdata;
  end

  assign io_out   = r_io;
  assign w_rd_val = (w_rd_addr == IO_A) ? r_io : w_mem_rdata;
`else
  assign w_rd_val = w_mem_rdata;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and transaction control; a write during a read is dropped
  // and flagged but does not disturb the read in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_oe_nxt    = r_oe;
    w_err_nxt   = 1'b0;
    w_latch     = 1'b0;
    w_cap       = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd && wr) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_ERR_HOLD;
        end else if (rd) begin
          w_latch = 1'b1;
          if (RD_LAT == 0) begin
            w_cnt_nxt   = 2'd0;
            w_cap       = 1'b1;
            w_oe_nxt    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_cnt_nxt   = LAT_CNT;
            w_state_nxt = S_WAIT;
          end
        end else if (wr) begin
          w_we = 1'b1;
        end
      end
      S_WAIT: begin
        if (wr) w_err_nxt = 1'b1;
        if (!rd) begin
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = 2'd0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt <= 2'd1) begin
          w_cnt_nxt   = 2'd0;
          w_cap       = 1'b1;
          w_oe_nxt    = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      S_RESP: begin
        if (wr) w_err_nxt = 1'b1;
        if (!rd) begin
          w_oe_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR_HOLD: begin
        if (!rd && !wr) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transaction registers: wait counter, latched address, read data, flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 2'd0;
      r_addr  <= '0;
      r_rdata <= '0;
      r_oe    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_oe  <= w_oe_nxt;
      r_err <= w_err_nxt;
      if (w_latch) r_addr  <= addr;
      if (w_cap)   r_rdata <= w_rd_val;
    end
  end

  assign rdata    = r_rdata;
  assign rdata_oe = r_oe;
  assign err      = r_err;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_target.sv
// Bench for bus_target: three instances (RD_LAT = 0, 1, 3) share one set of
// bus inputs. Table vectors and hand sequences check fixed expectations;
// a random phase compares every instance against a transaction-level model.
module tb_bus_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd, wr;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata_o [3];
  logic       oe_o    [3];
  logic       busy_o  [3];
  logic       err_o   [3];
`ifdef BUS_TARGET_IO_EN
  logic [7:0] io_o    [3];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_target #(.RD_LAT(0)) u0 (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata_o[0]), .rdata_oe(oe_o[0]), .busy(busy_o[0]), .err(err_o[0])
`ifdef BUS_TARGET_IO_EN
    , .io_out(io_o[0])
`endif
  );
  bus_target #(.RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata_o[1]), .rdata_oe(oe_o[1]), .busy(busy_o[1]), .err(err_o[1])
`ifdef BUS_TARGET_IO_EN
    , .io_out(io_o[1])
`endif
  );
  bus_target #(.RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata_o[2]), .rdata_oe(oe_o[2]), .busy(busy_o[2]), .err(err_o[2])
`ifdef BUS_TARGET_IO_EN
    , .io_out(io_o[2])
`endif
  );

  // ---------------- reference model (one per instance) ----------------
  // mode: 0 idle, 1 waiting for data, 2 responding, 3 holding after conflict
  int         lat [3] = '{0, 1, 3};
  int         m_mode [3];
  int         m_el   [3];
  logic [4:0] m_ra   [3];
  logic [7:0] m_mem  [3][32];
  logic [7:0] m_rdata[3];
  logic       m_oe   [3];
  logic       m_err  [3];
`ifdef BUS_TARGET_IO_EN
  logic [7:0] m_io   [3];
`endif

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_el[i] = 0; m_ra[i] = '0;
      m_rdata[i] = '0; m_oe[i] = 1'b0; m_err[i] = 1'b0;
      for (int j = 0; j < 32; j++) m_mem[i][j] = '0;
`ifdef BUS_TARGET_IO_EN
      m_io[i] = '0;
`endif
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic [4:0] a,
                            input logic [7:0] d);
    for (int i = 0; i < 3; i++) begin
      m_err[i] = 1'b0;
      case (m_mode[i])
        0: begin
          if (r && w) begin
            m_err[i] = 1'b1; m_mode[i] = 3;
          end else if (r) begin
            m_ra[i] = a; m_el[i] = 0;
            if (lat[i] == 0) begin
              m_rdata[i] = m_mem[i][a]; m_oe[i] = 1'b1; m_mode[i] = 2;
            end else begin
              m_mode[i] = 1;
            end
          end else if (w) begin
            m_mem[i][a] = d;
`ifdef BUS_TARGET_IO_EN
            if (a == 5'h1F) m_io[i] = d;
`endif
          end
        end
        1: begin
          if (w) m_err[i] = 1'b1;
          if (!r) begin
            m_err[i] = 1'b1; m_mode[i] = 0;
          end else begin
            m_el[i]++;
            if (m_el[i] >= lat[i]) begin
              m_rdata[i] = m_mem[i][m_ra[i]]; m_oe[i] = 1'b1; m_mode[i] = 2;
            end
          end
        end
        2: begin
          if (w) m_err[i] = 1'b1;
          if (!r) begin
            m_oe[i] = 1'b0; m_mode[i] = 0;
          end
        end
        default: begin
          if (!r && !w) m_mode[i] = 0;
        end
      endcase
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge sample them, advance the model, then
  // settle just after the edge so outputs can be checked.
  task automatic step(input logic r, input logic w, input logic [4:0] a,
                      input logic [7:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    model_step(r, w, a, d);
    #1;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [4:0] a;
    logic [7:0] d;
    logic       oe;
    logic [7:0] rdata;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // Vectors for the RD_LAT=1 instance; expected outputs follow each edge.
    tbl[0]  = '{1'b0, 1'b1, 5'h03, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0}; // write A5 -> 3
    tbl[1]  = '{1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1}; // read starts
    tbl[2]  = '{1'b1, 1'b0, 5'h03, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1}; // data valid
    tbl[3]  = '{1'b1, 1'b0, 5'h07, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1}; // addr ignored
    tbl[4]  = '{1'b0, 1'b0, 5'h07, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0}; // oe drops
    tbl[5]  = '{1'b1, 1'b1, 5'h05, 8'hFF, 1'b0, 8'hA5, 1'b1, 1'b1}; // conflict
    tbl[6]  = '{1'b1, 1'b0, 5'h05, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1}; // held, no re-pulse
    tbl[7]  = '{1'b0, 1'b0, 5'h05, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0}; // back to idle
    tbl[8]  = '{1'b1, 1'b0, 5'h05, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 5'h05, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1}; // mem[5] still 0
    tbl[10] = '{1'b1, 1'b1, 5'h05, 8'h77, 1'b1, 8'h00, 1'b1, 1'b1}; // wr in RESP
    tbl[11] = '{1'b0, 1'b0, 5'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 5'h03, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 5'h03, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 5'h05, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 5'h05, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1}; // dropped write
    tbl[17] = '{1'b0, 1'b0, 5'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      chk8($sformatf("reset_rdata%0d", i), rdata_o[i], 8'h00);
      chk1($sformatf("reset_oe%0d", i), oe_o[i], 1'b0);
      chk1($sformatf("reset_busy%0d", i), busy_o[i], 1'b0);
      chk1($sformatf("reset_err%0d", i), err_o[i], 1'b0);
`ifdef BUS_TARGET_IO_EN
      chk8($sformatf("reset_io%0d", i), io_o[i], 8'h00);
`endif
    end
    @(negedge clk);
    rst = 1'b0;

    // Table vectors
    for (int n = 0; n < 18; n++) begin
      step(tbl[n].rd, tbl[n].wr, tbl[n].a, tbl[n].d);
      chk1($sformatf("vec%0d_oe", n), oe_o[1], tbl[n].oe);
      chk8($sformatf("vec%0d_rdata", n), rdata_o[1], tbl[n].rdata);
      chk1($sformatf("vec%0d_err", n), err_o[1], tbl[n].err);
      chk1($sformatf("vec%0d_busy", n), busy_o[1], tbl[n].busy);
    end

    // Latency sweep: RD_LAT=0 valid at the sample edge, RD_LAT=3 three later
    step(1'b0, 1'b1, 5'h10, 8'h3C);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 5'h10, 8'h00);
      chk1($sformatf("lat0_oe_k%0d", k), oe_o[0], 1'b1);
      chk8($sformatf("lat0_rdata_k%0d", k), rdata_o[0], 8'h3C);
      chk1($sformatf("lat3_oe_k%0d", k), oe_o[2], (k >= 3));
    end
    chk8("lat3_rdata", rdata_o[2], 8'h3C);
    step(1'b0, 1'b0, 5'h10, 8'h00);
    chk1("lat3_oe_release", oe_o[2], 1'b0);

    // Read abort on RD_LAT=3 after one wait cycle
    step(1'b1, 1'b0, 5'h02, 8'h00);
    chk1("abort_busy_start", busy_o[2], 1'b1);
    step(1'b1, 1'b0, 5'h02, 8'h00);
    chk1("abort_oe_wait", oe_o[2], 1'b0);
    step(1'b0, 1'b0, 5'h02, 8'h00);
    chk1("abort_err", err_o[2], 1'b1);
    chk1("abort_busy", busy_o[2], 1'b0);
    chk1("abort_oe", oe_o[2], 1'b0);
    step(1'b0, 1'b0, 5'h02, 8'h00);
    chk1("abort_err_once", err_o[2], 1'b0);
    chk1("abort_oe_after", oe_o[2], 1'b0);

`ifdef BUS_TARGET_IO_EN
    // I/O port write and readback
    step(1'b0, 1'b1, 5'h1F, 8'h5A);
    chk8("io_write", io_o[1], 8'h5A);
    step(1'b1, 1'b0, 5'h1F, 8'h00);
    step(1'b1, 1'b0, 5'h1F, 8'h00);
    chk8("io_read", rdata_o[1], 8'h5A);
    step(1'b0, 1'b0, 5'h1F, 8'h00);
`endif

    // Reset while RD_LAT=1 instance is responding
    step(1'b1, 1'b0, 5'h03, 8'h00);
    step(1'b1, 1'b0, 5'h03, 8'h00);
    chk1("prerst_oe", oe_o[1], 1'b1);
    chk8("prerst_rdata", rdata_o[1], 8'hA5);
    rst = 1'b1;
    #1;
    chk1("rst_oe", oe_o[1], 1'b0);
    chk8("rst_rdata", rdata_o[1], 8'h00);
    chk1("rst_busy", busy_o[1], 1'b0);
`ifdef BUS_TARGET_IO_EN
    chk8("rst_io", io_o[1], 8'h00);
`endif
    model_reset();
    rd = 1'b0;
    #2;
    rst = 1'b0;
    step(1'b1, 1'b0, 5'h03, 8'h00);
    step(1'b1, 1'b0, 5'h03, 8'h00);
    chk1("postrst_oe", oe_o[1], 1'b1);
    chk8("postrst_rdata", rdata_o[1], 8'h00);
    step(1'b0, 1'b0, 5'h03, 8'h00);

    // Randomized traffic against the model
    begin
      logic       r_n, w_n, prev_rd;
      logic [4:0] a_n;
      logic [7:0] d_n;
      bit         all_idle;
      prev_rd = 1'b0;
      for (int c = 0; c < 400; c++) begin
        all_idle = (m_mode[0] == 0) && (m_mode[1] == 0) && (m_mode[2] == 0);
        r_n = prev_rd ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        w_n = !r_n && ($urandom_range(0, 1) == 1);
        if (all_idle && !prev_rd && ($urandom_range(0, 15) == 0)) begin
          r_n = 1'b1; w_n = 1'b1;
        end
        a_n = 5'($urandom_range(0, 31));
        d_n = 8'($urandom_range(0, 255));
        step(r_n, w_n, a_n, d_n);
        prev_rd = r_n;
        for (int i = 0; i < 3; i++) begin
          chk1($sformatf("rnd%0d_oe%0d", c, i), oe_o[i], m_oe[i]);
          chk8($sformatf("rnd%0d_rdata%0d", c, i), rdata_o[i], m_rdata[i]);
          chk1($sformatf("rnd%0d_err%0d", c, i), err_o[i], m_err[i]);
          chk1($sformatf("rnd%0d_busy%0d", c, i), busy_o[i], (m_mode[i] != 0));
`ifdef BUS_TARGET_IO_EN
          chk8($sformatf("rnd%0d_io%0d", c, i), io_o[i], m_io[i]);
`endif
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
